// File: rtl/debug_snapshot_tx_pkg.sv
// Shared definitions for the debug snapshot transmitter: frame header,
// FSM state encoding and the payload byte-count helper.
package dbg_pkg;

    localparam logic [7:0] FRAME_HDR = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SEND    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_NEXT_CH = 3'd3,
        ST_FIN     = 3'd4
    } state_t;

    function automatic int nb_bytes(input int nb_snap, input int nb_data);
        return (nb_snap + nb_data - 1) / nb_data;
    endfunction

endpackage

// File: rtl/debug_snapshot_tx_mux.sv
// Picks payload byte [ch][idx] out of the latched snapshot vector; bits beyond
// NB_SNAP in the final byte read as zero.
module snapshot_byte_mux
    import dbg_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_SNAP = 144,
    parameter int N_CH    = 5,
    parameter int NB_CH   = 3,
    parameter int NB_IDX  = 5
) (
    input  logic [N_CH*NB_SNAP-1:0] i_snap,
    input  logic [NB_CH-1:0]        i_ch,
    input  logic [NB_IDX-1:0]       i_idx,
    output logic [NB_DATA-1:0]      o_byte
);

    localparam int NB_BYTES = nb_bytes(NB_SNAP, NB_DATA);

    logic [NB_SNAP-1:0]          chan;
    logic [NB_BYTES*NB_DATA-1:0] padded;

    always_comb begin
        chan = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (i_ch == NB_CH'(k)) begin
                chan = i_snap[k*NB_SNAP +: NB_SNAP];
            end
        end
        padded = '0;
        padded[NB_SNAP-1:0] = chan;
        o_byte = '0;
        for (int b = 0; b < NB_BYTES; b++) begin
            if (i_idx == NB_IDX'(b)) begin
                o_byte = padded[b*NB_DATA +: NB_DATA];
            end
        end
    end

endmodule

// File: rtl/debug_snapshot_tx.sv
// Latches pipeline snapshot channels and streams them to the UART as
// framed packets: 0xA5, channel id, payload (LSB byte first), XOR checksum.
//
// state   | meaning
// IDLE    | waiting for a dump request
// SEND    | pulse tx_start with the current byte
// WAIT    | hold the byte until the UART reports txDone
// NEXT_CH | advance to the following channel in an all-channel dump
// FIN     | pulse done, drop busy
module debug_snapshot_tx
    import dbg_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_SNAP = 144,
    parameter int N_CH    = 5,
    parameter int NB_CH   = 3
) (
    input  logic                    clk,
    input  logic                    i_reset,
    input  logic                    i_req,
    input  logic                    i_all,
    input  logic [NB_CH-1:0]        i_ch_sel,
    input  logic [N_CH*NB_SNAP-1:0] i_snapshot,
    input  logic                    i_txDone,
    output logic                    o_tx_start,
    output logic [NB_DATA-1:0]      o_data,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_err
);

    localparam int NB_BYTES = nb_bytes(NB_SNAP, NB_DATA);
    localparam int NB_POS   = $clog2(NB_BYTES + 3);

    localparam logic [NB_POS-1:0] POS_CH   = NB_POS'(1);
    localparam logic [NB_POS-1:0] POS_LAST = NB_POS'(NB_BYTES + 2);
    localparam logic [NB_CH-1:0]  LAST_CH  = NB_CH'(N_CH - 1);
    localparam logic [NB_CH:0]    N_CH_EXT = (NB_CH + 1)'(N_CH);

    state_t                  state_q, state_d;
    logic [N_CH*NB_SNAP-1:0] snap_q, snap_d;
    logic                    all_q, all_d;
    logic [NB_CH-1:0]        ch_q, ch_d;
    logic [NB_POS-1:0]       pos_q, pos_d;
    logic [NB_DATA-1:0]      csum_q, csum_d;
    logic                    err_q, err_d;

    logic [NB_DATA-1:0]      pay_byte;
    logic [NB_DATA-1:0]      cur_byte;

    snapshot_byte_mux #(
        .NB_DATA (NB_DATA),
        .NB_SNAP (NB_SNAP),
        .N_CH    (N_CH),
        .NB_CH   (NB_CH),
        .NB_IDX  (NB_POS)
    ) u_mux (
        .i_snap (snap_q),
        .i_ch   (ch_q),
        .i_idx  (pos_q - NB_POS'(2)),
        .o_byte (pay_byte)
    );

    // pos_q walks the frame: 0 header, 1 channel id, payload, then checksum
    always_comb begin
        if (pos_q == '0) begin
            cur_byte = NB_DATA'(FRAME_HDR);
        end else if (pos_q == POS_CH) begin
            cur_byte = NB_DATA'(ch_q);
        end else if (pos_q == POS_LAST) begin
            cur_byte = csum_q;
        end else begin
            cur_byte = pay_byte;
        end
    end

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        all_d      = all_q;
        ch_d       = ch_q;
        pos_d      = pos_q;
        csum_d     = csum_q;
        err_d      = 1'b0;
        o_tx_start = 1'b0;
        o_data     = '0;
        o_busy     = 1'b0;
        o_done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    if (!i_all && ({1'b0, i_ch_sel} >= N_CH_EXT)) begin
                        err_d = 1'b1;
                    end else begin
                        snap_d  = i_snapshot;
                        all_d   = i_all;
                        ch_d    = i_all ? '0 : i_ch_sel;
                        pos_d   = '0;
                        csum_d  = '0;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_SEND: begin
                o_tx_start = 1'b1;
                o_busy     = 1'b1;
                o_data     = cur_byte;
                if (pos_q != '0 && pos_q != POS_LAST) begin
                    csum_d = csum_q ^ cur_byte;
                end
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                o_busy = 1'b1;
                o_data = cur_byte;
                if (i_txDone) begin
                    if (pos_q == POS_LAST) begin
                        state_d = (all_q && ch_q != LAST_CH) ? ST_NEXT_CH : ST_FIN;
                    end else begin
                        pos_d   = pos_q + NB_POS'(1);
                        state_d = ST_SEND;
                    end
                end
            end
            ST_NEXT_CH: begin
                o_busy = 1'b1;
                if (all_q && ch_q != LAST_CH) begin
                    ch_d    = ch_q + NB_CH'(1);
                    pos_d   = '0;
                    csum_d  = '0;
                    state_d = ST_SEND;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                o_done  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_err = err_q;

    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            snap_q  <= '0;
            all_q   <= 1'b0;
            ch_q    <= '0;
            pos_q   <= '0;
            csum_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            all_q   <= all_d;
            ch_q    <= ch_d;
            pos_q   <= pos_d;
            csum_q  <= csum_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_debug_snapshot_tx.sv
// Scoreboard bench for debug_snapshot_tx: two small instances (16-bit and
// 12-bit channels, two channels each) served by a simple UART responder.
module tb_debug_snapshot_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        a_req, a_all, a_txDone;
    logic [1:0]  a_ch;
    logic [31:0] a_snap;
    logic        a_tx_start, a_busy, a_done, a_err;
    logic [7:0]  a_data;

    logic        b_req, b_all, b_txDone;
    logic [1:0]  b_ch;
    logic [23:0] b_snap;
    logic        b_tx_start, b_busy, b_done, b_err;
    logic [7:0]  b_data;

    debug_snapshot_tx #(.NB_DATA(8), .NB_SNAP(16), .N_CH(2), .NB_CH(2)) dut_a (
        .clk(clk), .i_reset(rst), .i_req(a_req), .i_all(a_all), .i_ch_sel(a_ch),
        .i_snapshot(a_snap), .i_txDone(a_txDone), .o_tx_start(a_tx_start),
        .o_data(a_data), .o_busy(a_busy), .o_done(a_done), .o_err(a_err)
    );

    debug_snapshot_tx #(.NB_DATA(8), .NB_SNAP(12), .N_CH(2), .NB_CH(2)) dut_b (
        .clk(clk), .i_reset(rst), .i_req(b_req), .i_all(b_all), .i_ch_sel(b_ch),
        .i_snapshot(b_snap), .i_txDone(b_txDone), .o_tx_start(b_tx_start),
        .o_data(b_data), .o_busy(b_busy), .o_done(b_done), .o_err(b_err)
    );

    int         total = 0;
    int         bad   = 0;
    logic [7:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for tx_start, captures the byte, then answers with txDone
    // after `delay` wait cycles. viol counts repeated tx_start or o_data changes
    // while the byte is outstanding.
    task automatic uart_byte(input bit use_b, input int delay, output bit ok,
                             output logic [7:0] got, output int viol);
        ok   = 1'b0;
        got  = '0;
        viol = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            if ((use_b ? b_tx_start : a_tx_start) === 1'b1) ok = 1'b1;
            else tick();
        end
        if (ok) begin
            got = use_b ? b_data : a_data;
            tick();
            for (int d = 0; d <= delay; d++) begin
                if ((use_b ? b_tx_start : a_tx_start) !== 1'b0) viol++;
                if ((use_b ? b_data : a_data) !== got) viol++;
                if (d == delay) begin
                    if (use_b) b_txDone = 1'b1;
                    else a_txDone = 1'b1;
                end
                tick();
            end
            a_txDone = 1'b0;
            b_txDone = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_req = 1'b1;
        b_req = 1'b1;
        repeat (3) tick();
        total++;
        if ({a_tx_start, a_data, a_busy, a_done, a_err} !== 12'h000) begin
            bad++;
            $display("FAIL reset_a: got %h want 000", {a_tx_start, a_data, a_busy, a_done, a_err});
        end
        total++;
        if ({b_tx_start, b_data, b_busy, b_done, b_err} !== 12'h000) begin
            bad++;
            $display("FAIL reset_b: got %h want 000", {b_tx_start, b_data, b_busy, b_done, b_err});
        end
        a_req = 1'b0;
        b_req = 1'b0;
        rst   = 1'b0;
        tick();
        total++;
        if ({a_busy, a_tx_start, b_busy, b_tx_start} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_idle: got %b want 0000", {a_busy, a_tx_start, b_busy, b_tx_start});
        end
    endtask

    task automatic serve_and_check(input bit use_b, input int n, input string name);
        bit         ok;
        logic [7:0] got;
        logic [7:0] exp;
        int         viol;
        for (int k = 0; k < n; k++) begin
            uart_byte(use_b, k % 3, ok, got, viol);
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
            total++;
            if (!ok || viol != 0 || got !== exp) begin
                bad++;
                $display("FAIL %s_byte%0d: got %h (seen=%0d viol=%0d) want %h", name, k, got, ok, viol, exp);
            end
            if (k != n - 1) begin
                total++;
                if ((use_b ? {b_busy, b_done} : {a_busy, a_done}) !== 2'b10) begin
                    bad++;
                    $display("FAIL %s_busy%0d: got busy/done %b want 10", name, k,
                             use_b ? {b_busy, b_done} : {a_busy, a_done});
                end
            end
        end
        total++;
        if ((use_b ? {b_busy, b_done} : {a_busy, a_done}) !== 2'b01) begin
            bad++;
            $display("FAIL %s_done: got busy/done %b want 01", name, use_b ? {b_busy, b_done} : {a_busy, a_done});
        end
        tick();
        total++;
        if ((use_b ? {b_busy, b_done} : {a_busy, a_done}) !== 2'b00) begin
            bad++;
            $display("FAIL %s_done_pulse: got busy/done %b want 00", name, use_b ? {b_busy, b_done} : {a_busy, a_done});
        end
    endtask

    task automatic test_single();
        a_snap = {16'hBEEF, 16'hCAFE};
        a_all  = 1'b0;
        a_ch   = 2'd1;
        exp_q  = '{8'hA5, 8'h01, 8'hEF, 8'hBE, 8'h50};
        a_req  = 1'b1;
        tick();
        a_req = 1'b0;
        total++;
        if ({a_busy, a_tx_start, a_data} !== {2'b11, 8'hA5}) begin
            bad++;
            $display("FAIL single_first: got busy/start/data %b/%b/%h want 1/1/a5", a_busy, a_tx_start, a_data);
        end
        serve_and_check(1'b0, 5, "single");
    endtask

    task automatic test_all_channels();
        a_snap = {16'hBEEF, 16'h1234};
        a_all  = 1'b1;
        a_ch   = 2'd3;
        exp_q  = '{8'hA5, 8'h00, 8'h34, 8'h12, 8'h26, 8'hA5, 8'h01, 8'hEF, 8'hBE, 8'h50};
        a_req  = 1'b1;
        tick();
        a_req = 1'b0;
        total++;
        if ({a_err, a_busy} !== 2'b01) begin
            bad++;
            $display("FAIL all_accept: got err/busy %b want 01", {a_err, a_busy});
        end
        serve_and_check(1'b0, 10, "all");
    endtask

    task automatic test_pad();
        b_snap = {12'h123, 12'hABC};
        b_all  = 1'b0;
        b_ch   = 2'd0;
        exp_q  = '{8'hA5, 8'h00, 8'hBC, 8'h0A, 8'hB6};
        b_req  = 1'b1;
        tick();
        b_req  = 1'b0;
        b_snap = '1;
        serve_and_check(1'b1, 5, "pad");
    endtask

    task automatic test_invalid();
        int starts;
        for (int k = 0; k < 2; k++) begin
            a_all = 1'b0;
            a_ch  = (k == 0) ? 2'd3 : 2'd2;
            a_req = 1'b1;
            tick();
            a_req = 1'b0;
            total++;
            if ({a_err, a_tx_start, a_busy} !== 3'b100) begin
                bad++;
                $display("FAIL invalid%0d_err: got err/start/busy %b want 100", k, {a_err, a_tx_start, a_busy});
            end
            tick();
            starts = 0;
            for (int c = 0; c < 8; c++) begin
                if (a_tx_start !== 1'b0 || a_busy !== 1'b0 || a_err !== 1'b0) starts++;
                tick();
            end
            total++;
            if (starts != 0) begin
                bad++;
                $display("FAIL invalid%0d_quiet: got %0d active cycles want 0", k, starts);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit         ok;
        logic [7:0] got;
        logic [7:0] exp;
        int         viol;
        int         act;
        a_snap = {16'hBEEF, 16'h1234};
        a_all  = 1'b0;
        a_ch   = 2'd0;
        exp_q  = '{8'hA5, 8'h00};
        a_req  = 1'b1;
        tick();
        a_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            uart_byte(1'b0, 1, ok, got, viol);
            exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
            total++;
            if (!ok || viol != 0 || got !== exp) begin
                bad++;
                $display("FAIL rstmid_byte%0d: got %h (seen=%0d viol=%0d) want %h", k, got, ok, viol, exp);
            end
        end
        total++;
        if ({a_tx_start, a_data} !== {1'b1, 8'h34}) begin
            bad++;
            $display("FAIL rstmid_third: got start/data %b/%h want 1/34", a_tx_start, a_data);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({a_tx_start, a_data, a_busy, a_done, a_err} !== 12'h000) begin
            bad++;
            $display("FAIL rstmid_clear: got %h want 000", {a_tx_start, a_data, a_busy, a_done, a_err});
        end
        rst      = 1'b0;
        a_txDone = 1'b1;
        tick();
        a_txDone = 1'b0;
        act = 0;
        for (int c = 0; c < 8; c++) begin
            if (a_tx_start !== 1'b0 || a_busy !== 1'b0 || a_done !== 1'b0) act++;
            tick();
        end
        total++;
        if (act != 0) begin
            bad++;
            $display("FAIL rstmid_quiet: got %0d active cycles want 0", act);
        end
        exp_q.delete();
        exp_q = '{8'hA5, 8'h01, 8'hEF, 8'hBE, 8'h50};
        a_ch  = 2'd1;
        a_req = 1'b1;
        tick();
        a_req = 1'b0;
        serve_and_check(1'b0, 5, "rstmid_new");
    endtask

    task automatic test_back_to_back();
        int         nbytes = 0;
        int         ndone  = 0;
        logic [7:0] exp;
        a_snap   = {16'hBEEF, 16'h1234};
        a_all    = 1'b0;
        a_ch     = 2'd0;
        exp_q    = '{8'hA5, 8'h00, 8'h34, 8'h12, 8'h26};
        a_req    = 1'b1;
        a_txDone = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c == 1) a_ch = 2'd1;
            if (c == 6) a_req = 1'b0;
            if (a_tx_start === 1'b1) begin
                exp = (exp_q.size() != 0) ? exp_q.pop_front() : 8'hXX;
                total++;
                if (a_data !== exp) begin
                    bad++;
                    $display("FAIL b2b_byte%0d: got %h want %h", nbytes, a_data, exp);
                end
                nbytes++;
            end
            if (a_done === 1'b1) ndone++;
            tick();
        end
        a_txDone = 1'b0;
        a_req    = 1'b0;
        total++;
        if (nbytes != 5) begin
            bad++;
            $display("FAIL b2b_count: got %0d bytes want 5", nbytes);
        end
        total++;
        if (ndone != 1) begin
            bad++;
            $display("FAIL b2b_done: got %0d done pulses want 1", ndone);
        end
    endtask

    initial begin
        rst      = 1'b1;
        a_req    = 1'b0;
        a_all    = 1'b0;
        a_ch     = '0;
        a_snap   = '0;
        a_txDone = 1'b0;
        b_req    = 1'b0;
        b_all    = 1'b0;
        b_ch     = '0;
        b_snap   = '0;
        b_txDone = 1'b0;
        tick();
        test_reset();
        test_single();
        test_all_channels();
        test_pad();
        test_invalid();
        test_reset_mid();
        tick();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
